// File: rtl/bcd_adder_seq.sv
// bcd_adder_seq: sequential N-digit packed-BCD adder, one decimal digit per clock, LSD first.
// Latency: start accepted at edge t -> busy after t..t+DIGITS-1, done/sum/cout/err/hex after t+DIGITS.
//          An operand digit > 9 is caught at the accept edge: done and err follow it immediately.
// Backpressure: none; start is only sampled in IDLE, so a start while busy or done is dropped.
//
// Ports:
//   CLOCK_50      rising-edge clock
//   RESET         synchronous active-high reset, has priority over start
//   start         operation request (IDLE only)
//   a, b          packed BCD operands, digit k at [4k+3:4k]
//   cin           decimal carry-in (ignored when subtracting)
//   op            0 = add, 1 = subtract (effective only with BCD_SUB_EN defined)
//   sum, cout     registered result and decimal carry-out (subtract: 1 = no borrow)
//   err           an operand digit was greater than 9
//   busy, done    in-flight flag / one-cycle result-valid pulse
//   hex           active-low seven-segment patterns, slot k = [7k+6:7k], MSB = segment a;
//                 slot DIGITS shows cout, all slots blank until a valid, error-free result
//
// Optional feature macro: BCD_SUB_EN (nines'-complement subtract path).

module bcd_adder_seq #(
  parameter int DIGITS = 2
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET,
  input  logic                    start,
  input  logic [4*DIGITS-1:0]     a,
  input  logic [4*DIGITS-1:0]     b,
  input  logic                    cin,
  input  logic                    op,
  output logic [4*DIGITS-1:0]     sum,
  output logic                    cout,
  output logic                    err,
  output logic                    busy,
  output logic                    done,
  output logic [7*(DIGITS+1)-1:0] hex
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [4*DIGITS-1:0]   a_q;
  logic [4*DIGITS-1:0]   b_q;
  logic [IW-1:0]         idx_q;
  logic                  carry_q;
  logic [4*DIGITS-1:0]   sum_q;
  logic                  cout_q;
  logic                  err_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  valid_q;

`ifdef BCD_SUB_EN
  logic                  op_q;
`else
  // op has no function without the subtract path.
  logic                  unused_op;
  assign unused_op = op;
`endif

  // Per-digit datapath for the digit currently selected by idx_q.
  logic [3:0] a_dig;
  logic [3:0] b_dig;
  logic [3:0] b_eff;
  logic [4:0] t_d;
  logic [3:0] dig_d;
  logic       carry_d;

  function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        a_dig = a_q[4*k +: 4];
        b_dig = b_q[4*k +: 4];
      end
    end
    b_eff = b_dig;
`ifdef BCD_SUB_EN
    // Nines' complement; together with the forced carry-in this forms A + (10^N - 1 - B) + 1.
    if (op_q) b_eff = 4'd9 - b_dig;
`endif
    t_d = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry_q};
    if (t_d > 5'd9) begin
      dig_d   = 4'(t_d - 5'd10);
      carry_d = 1'b1;
    end else begin
      dig_d   = t_d[3:0];
      carry_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef BCD_SUB_EN
      op_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            idx_q   <= '0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef BCD_SUB_EN
            op_q    <= op;
            carry_q <= op ? 1'b1 : cin;
`else
            carry_q <= cin;
`endif
            if (has_bad_digit(a) || has_bad_digit(b)) begin
              // Skip the ripple entirely; result stays zero and the display blanks.
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end else begin
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= S_ADD;
            end
          end
        end

        S_ADD: begin
          for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) sum_q[4*k +: 4] <= dig_d;
          end
          carry_q <= carry_d;
          if (idx_q == LAST_IDX) begin
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end

        // One dead cycle so a start coinciding with done is dropped.
        S_DONE: state_q <= S_IDLE;

        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    hex = '1;
    if (valid_q && !err_q) begin
      for (int k = 0; k < DIGITS; k++) begin
        hex[7*k +: 7] = seg7(sum_q[4*k +: 4]);
      end
      hex[7*DIGITS +: 7] = seg7({3'b000, cout_q});
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_bcd_adder_seq.sv
module tb_bcd_adder_seq;

  localparam int D  = 2;
  localparam int W  = 4 * D;
  localparam int HW = 7 * (D + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  a, b;
  logic          cin, op;
  logic [W-1:0]  sum;
  logic          cout, err, busy, done;
  logic [HW-1:0] hex;

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  always #5 clk = ~clk;

  bcd_adder_seq #(.DIGITS(D)) dut (
    .CLOCK_50(clk), .RESET(rst), .start(start), .a(a), .b(b), .cin(cin), .op(op),
    .sum(sum), .cout(cout), .err(err), .busy(busy), .done(done), .hex(hex)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (decimal arithmetic) ----------------
  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int k = D - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r = '0;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic logic bad_bcd(input logic [W-1:0] v);
    logic r = 1'b0;
    for (int k = 0; k < D; k++) if (v[4*k +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  function automatic int pow10();
    int p = 1;
    for (int k = 0; k < D; k++) p = p * 10;
    return p;
  endfunction

  task automatic model(input logic [W-1:0] av, bv, input logic cv, ov,
                       output logic [W-1:0] es, output logic ec, output logic ee);
    int s;
    int p = pow10();
    ee = bad_bcd(av) || bad_bcd(bv);
    s  = bcd2int(av) + bcd2int(bv) + int'(cv);
`ifdef BCD_SUB_EN
    if (ov) s = bcd2int(av) - bcd2int(bv) + p;
`endif
    if (ee) begin
      es = '0;
      ec = 1'b0;
    end else begin
      es = int2bcd(s % p);
      ec = (s >= p);
    end
  endtask

  function automatic logic [HW-1:0] hex_model(input logic [W-1:0] s, input logic c, input logic e);
    logic [HW-1:0] h = '1;
    if (!e) begin
      for (int k = 0; k < D; k++) h[7*k +: 7] = seg_tbl[s[4*k +: 4]];
      h[7*D +: 7] = seg_tbl[c ? 1 : 0];
    end
    return h;
  endfunction

  // Issue one operation, wait (bounded) for done and check latency, busy width and result.
  task automatic do_op(input logic [W-1:0] av, bv, input logic cv, ov, input string tag);
    logic [W-1:0] es;
    logic ec, ee, got, overlap;
    int n, busy_cnt;
    model(av, bv, cv, ov, es, ec, ee);
    @(negedge clk);
    a = av; b = bv; cin = cv; op = ov; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0; overlap = 1'b0; n = 0; busy_cnt = 0;
    while (!got && n < 40) begin
      if (busy && done) overlap = 1'b1;
      if (done) got = 1'b1;
      else begin
        if (busy) busy_cnt++;
        n++;
        @(negedge clk);
      end
    end
    chk({tag, ".done_seen"}, 64'(got), 64'd1);
    chk({tag, ".latency"}, 64'(n), ee ? 64'd0 : 64'(D));
    chk({tag, ".busy_cycles"}, 64'(busy_cnt), ee ? 64'd0 : 64'(D));
    chk({tag, ".busy_done_overlap"}, 64'(overlap), 64'd0);
    chk({tag, ".sum"}, 64'(sum), 64'(es));
    chk({tag, ".cout"}, 64'(cout), 64'(ec));
    chk({tag, ".err"}, 64'(err), 64'(ee));
    chk({tag, ".hex"}, 64'(hex), 64'(hex_model(es, ec, ee)));
    @(negedge clk);
    chk({tag, ".done_pulse"}, 64'(done), 64'd0);
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int k = 0; k < D; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  initial begin
    logic [W-1:0] x1, y1, x2, y2, es;
    logic ec, ee, got;
    int n;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; op = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.sum", 64'(sum), 64'd0);
    chk("reset.cout", 64'(cout), 64'd0);
    chk("reset.err", 64'(err), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.hex", 64'(hex), 64'(HW'('1)));

    // 47 + 38 = 85, no carry out; digit 0 is 5, digit 1 is 8, carry slot 0
    do_op(8'h47, 8'h38, 1'b0, 1'b0, "add47_38");
    chk("add47_38.sum_const", 64'(sum), 64'h85);
    chk("add47_38.hex_const", 64'(hex), 64'({7'b0000001, 7'b0000000, 7'b0100100}));

    // 99 + 99 + 1 = 199
    do_op(8'h99, 8'h99, 1'b1, 1'b0, "add99_99c");
    chk("add99_99c.sum_const", 64'(sum), 64'h99);
    chk("add99_99c.cout_const", 64'(cout), 64'd1);

    // non-decimal digit
    do_op(8'h1A, 8'h05, 1'b0, 1'b0, "err1A");
    chk("err1A.hex_blank", 64'(hex), 64'(HW'('1)));
    do_op(8'h00, 8'hF0, 1'b1, 1'b0, "errF0");

    // boundaries
    do_op(8'h00, 8'h00, 1'b0, 1'b0, "zero");
    do_op(8'h99, 8'h00, 1'b1, 1'b0, "wrap");

    // start held high with changing operands: only the first set is used
    x1 = rand_bcd(); y1 = rand_bcd();
    @(negedge clk);
    a = x1; b = y1; cin = 1'b0; op = 1'b0; start = 1'b1;
    @(negedge clk);
    got = 1'b0; n = 0;
    while (!got && n < 40) begin
      if (done) got = 1'b1;
      else begin
        a = rand_bcd(); b = rand_bcd();
        n++;
        @(negedge clk);
      end
    end
    model(x1, y1, 1'b0, 1'b0, es, ec, ee);
    chk("held.done_seen", 64'(got), 64'd1);
    chk("held.sum", 64'(sum), 64'(es));
    chk("held.cout", 64'(cout), 64'(ec));
    x2 = rand_bcd(); y2 = rand_bcd();
    a = x2; b = y2;
    @(negedge clk);
    chk("held.ignored_busy", 64'(busy), 64'd0);
    chk("held.ignored_done", 64'(done), 64'd0);
    @(negedge clk);
    chk("held.next_accept", 64'(busy), 64'd1);
    start = 1'b0;
    got = 1'b0; n = 0;
    while (!got && n < 40) begin
      if (done) got = 1'b1;
      else begin n++; @(negedge clk); end
    end
    model(x2, y2, 1'b0, 1'b0, es, ec, ee);
    chk("held2.done_seen", 64'(got), 64'd1);
    chk("held2.sum", 64'(sum), 64'(es));
    chk("held2.cout", 64'(cout), 64'(ec));

    // reset the cycle after start
    @(negedge clk);
    a = 8'h55; b = 8'h44; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    got = 1'b0;
    for (int i = 0; i < D + 3; i++) begin
      if (done || busy) got = 1'b1;
      @(negedge clk);
    end
    chk("rst_mid.no_activity", 64'(got), 64'd0);
    chk("rst_mid.sum", 64'(sum), 64'd0);
    chk("rst_mid.hex", 64'(hex), 64'(HW'('1)));
    do_op(8'h12, 8'h34, 1'b0, 1'b0, "after_rst");

`ifdef BCD_SUB_EN
    do_op(8'h52, 8'h17, 1'b0, 1'b1, "sub52_17");
    chk("sub52_17.sum_const", 64'(sum), 64'h35);
    chk("sub52_17.cout_const", 64'(cout), 64'd1);
    do_op(8'h17, 8'h52, 1'b1, 1'b1, "sub17_52");
    chk("sub17_52.sum_const", 64'(sum), 64'h65);
    chk("sub17_52.cout_const", 64'(cout), 64'd0);
`endif

    // randomized operations, occasionally with a corrupted digit
    for (int i = 0; i < 25; i++) begin
      x1 = rand_bcd(); y1 = rand_bcd();
      if ($urandom_range(0, 7) == 0) x1[3:0] = 4'($urandom_range(10, 15));
      do_op(x1, y1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
